// File: rtl/calc_arbiter.sv
// Round-robin arbiter that lends one shared add/sub unit to two requesters,
// holds the operands for SETTLE_CYCLES, then presents the captured result.
module calc_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req0_op,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic       req1_op,
    output logic       req1_ready,
    output logic [7:0] calc_num1,
    output logic [7:0] calc_num2,
    output logic       calc_sel,
    input  logic [7:0] calc_out,
    input  logic       calc_flow,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic       rsp_flow,
    input  logic       rsp_ready,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_last;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_op;
    logic       r_id;
    logic       r_rsp_valid;
    logic       r_rsp_id;
    logic [7:0] r_rsp_data;
    logic       r_rsp_flow;
    logic       w_grant;
    logic       w_grant_id;

    // Reset gates the grant so a requester never sees ready while rst is high.
    always_comb begin
        // NOTE: defaults first so no path leaves these unassigned and infers a latch.
        w_grant    = 1'b0;
        w_grant_id = 1'b0;
        if (!rst && r_state == IDLE && (req0_valid || req1_valid)) begin
            w_grant = 1'b1;
            if (req0_valid && req1_valid) w_grant_id = ~r_last;
            else                          w_grant_id = req1_valid;
        end
    end

    assign req0_ready = w_grant && !w_grant_id;
    assign req1_ready = w_grant && w_grant_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_last      <= 1'b1;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= 1'b0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_flow  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_a     <= w_grant_id ? req1_a  : req0_a;
                        r_b     <= w_grant_id ? req1_b  : req0_b;
                        r_op    <= w_grant_id ? req1_op : req0_op;
                        r_id    <= w_grant_id;
                        r_last  <= w_grant_id;
                        r_cnt   <= '0;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_cnt == LAST_CNT) begin
                        r_rsp_data  <= calc_out;
                        r_rsp_flow  <= calc_flow;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign calc_num1 = r_a;
    assign calc_num2 = r_b;
    assign calc_sel  = r_op;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_flow  = r_rsp_flow;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_calc_arbiter.sv
// Bench for calc_arbiter: two instances (SETTLE_CYCLES 1 and 3) share stimulus,
// each with its own model of the add/sub unit and its own response scoreboard.
module tb_calc_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req0_op = 1'b0, req1_valid = 1'b0, req1_op = 1'b0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       rsp_ready = 1'b0;

    logic       s1_req0_ready, s1_req1_ready, s1_calc_sel, s1_calc_flow;
    logic       s1_rsp_valid, s1_rsp_id, s1_rsp_flow, s1_busy;
    logic [7:0] s1_calc_num1, s1_calc_num2, s1_calc_out, s1_rsp_data;
    logic       s3_req0_ready, s3_req1_ready, s3_calc_sel, s3_calc_flow;
    logic       s3_rsp_valid, s3_rsp_id, s3_rsp_flow, s3_busy;
    logic [7:0] s3_calc_num1, s3_calc_num2, s3_calc_out, s3_rsp_data;

    int checks = 0;
    int errors = 0;

    logic [9:0] sb1[$];
    logic [9:0] sb3[$];
    logic [9:0] exp1, exp3;
    logic [8:0] u1, u3;

    // Shared add/sub unit: {carry/borrow, result}; borrow is 1 when a < b.
    function automatic logic [8:0] unit(input logic [7:0] a, input logic [7:0] b, input logic sel);
        return sel ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    endfunction

    assign {s1_calc_flow, s1_calc_out} = unit(s1_calc_num1, s1_calc_num2, s1_calc_sel);
    assign {s3_calc_flow, s3_calc_out} = unit(s3_calc_num1, s3_calc_num2, s3_calc_sel);

    calc_arbiter #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(s1_req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(s1_req1_ready),
        .calc_num1(s1_calc_num1), .calc_num2(s1_calc_num2), .calc_sel(s1_calc_sel),
        .calc_out(s1_calc_out), .calc_flow(s1_calc_flow),
        .rsp_valid(s1_rsp_valid), .rsp_id(s1_rsp_id), .rsp_data(s1_rsp_data), .rsp_flow(s1_rsp_flow),
        .rsp_ready(rsp_ready), .busy(s1_busy)
    );

    calc_arbiter #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(s3_req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(s3_req1_ready),
        .calc_num1(s3_calc_num1), .calc_num2(s3_calc_num2), .calc_sel(s3_calc_sel),
        .calc_out(s3_calc_out), .calc_flow(s3_calc_flow),
        .rsp_valid(s3_rsp_valid), .rsp_id(s3_rsp_id), .rsp_data(s3_rsp_data), .rsp_flow(s3_rsp_flow),
        .rsp_ready(rsp_ready), .busy(s3_busy)
    );

    always #5 clk = ~clk;

    // Scoreboard for the SETTLE_CYCLES=1 instance.
    always @(negedge clk) begin
        if (rst) begin
            sb1.delete();
            checks++;
            if ({s1_req0_ready, s1_req1_ready} !== 2'b00) begin
                errors++;
                $display("FAIL s1_ready_during_rst got %b%b want 00", s1_req0_ready, s1_req1_ready);
            end
        end else begin
            if (s1_req0_ready === 1'b1) begin
                u1 = unit(req0_a, req0_b, req0_op);
                sb1.push_back({1'b0, u1[7:0], u1[8]});
            end
            if (s1_req1_ready === 1'b1) begin
                u1 = unit(req1_a, req1_b, req1_op);
                sb1.push_back({1'b1, u1[7:0], u1[8]});
            end
            if (s1_rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                checks++;
                if (sb1.size() == 0) begin
                    errors++;
                    $display("FAIL s1_rsp_unexpected got id=%b data=%0d flow=%b want none", s1_rsp_id, s1_rsp_data, s1_rsp_flow);
                end else begin
                    exp1 = sb1.pop_front();
                    if ({s1_rsp_id, s1_rsp_data, s1_rsp_flow} !== exp1) begin
                        errors++;
                        $display("FAIL s1_rsp got id=%b data=%0d flow=%b want id=%b data=%0d flow=%b",
                                 s1_rsp_id, s1_rsp_data, s1_rsp_flow, exp1[9], exp1[8:1], exp1[0]);
                    end
                end
            end
        end
    end

    // Scoreboard for the SETTLE_CYCLES=3 instance.
    always @(negedge clk) begin
        if (rst) begin
            sb3.delete();
            checks++;
            if ({s3_req0_ready, s3_req1_ready} !== 2'b00) begin
                errors++;
                $display("FAIL s3_ready_during_rst got %b%b want 00", s3_req0_ready, s3_req1_ready);
            end
        end else begin
            if (s3_req0_ready === 1'b1) begin
                u3 = unit(req0_a, req0_b, req0_op);
                sb3.push_back({1'b0, u3[7:0], u3[8]});
            end
            if (s3_req1_ready === 1'b1) begin
                u3 = unit(req1_a, req1_b, req1_op);
                sb3.push_back({1'b1, u3[7:0], u3[8]});
            end
            if (s3_rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                checks++;
                if (sb3.size() == 0) begin
                    errors++;
                    $display("FAIL s3_rsp_unexpected got id=%b data=%0d flow=%b want none", s3_rsp_id, s3_rsp_data, s3_rsp_flow);
                end else begin
                    exp3 = sb3.pop_front();
                    if ({s3_rsp_id, s3_rsp_data, s3_rsp_flow} !== exp3) begin
                        errors++;
                        $display("FAIL s3_rsp got id=%b data=%0d flow=%b want id=%b data=%0d flow=%b",
                                 s3_rsp_id, s3_rsp_data, s3_rsp_flow, exp3[9], exp3[8:1], exp3[0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        while ((s1_busy || s3_busy) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (s1_busy !== 1'b0 || s3_busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout got busy=%b%b want 00", s1_busy, s3_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if ({s1_calc_num1, s1_calc_num2, s1_calc_sel, s1_rsp_valid, s1_rsp_id, s1_rsp_data,
             s1_rsp_flow, s1_busy, s1_req0_ready, s1_req1_ready} !== 31'd0) begin
            errors++;
            $display("FAIL s1_reset_outputs got num1=%0d num2=%0d sel=%b rv=%b id=%b data=%0d flow=%b busy=%b rdy=%b%b want all 0",
                     s1_calc_num1, s1_calc_num2, s1_calc_sel, s1_rsp_valid, s1_rsp_id, s1_rsp_data,
                     s1_rsp_flow, s1_busy, s1_req0_ready, s1_req1_ready);
        end
        checks++;
        if ({s3_calc_num1, s3_calc_num2, s3_calc_sel, s3_rsp_valid, s3_rsp_id, s3_rsp_data,
             s3_rsp_flow, s3_busy, s3_req0_ready, s3_req1_ready} !== 31'd0) begin
            errors++;
            $display("FAIL s3_reset_outputs got num1=%0d num2=%0d busy=%b rdy=%b%b want all 0",
                     s3_calc_num1, s3_calc_num2, s3_busy, s3_req0_ready, s3_req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
    endtask

    // Both requesters valid from reset: grants must alternate 0,1,0,1 three cycles apart.
    task automatic test_contention();
        int   grants = 0;
        int   last_t = 0;
        int   cyc    = 0;
        logic exp_id = 1'b0;
        rsp_ready = 1'b1;
        req0_a = 8'd10; req0_b = 8'd3; req0_op = 1'b0;
        req1_a = 8'd50; req1_b = 8'd7; req1_op = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        while (grants < 4 && cyc < 40) begin
            @(negedge clk);
            if (s1_req0_ready || s1_req1_ready) begin
                checks++;
                if ({s1_req0_ready, s1_req1_ready} !== (exp_id ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL contention_grant%0d got rdy=%b%b want id=%b", grants, s1_req0_ready, s1_req1_ready, exp_id);
                end
                if (grants > 0) begin
                    checks++;
                    if (cyc - last_t != 3) begin
                        errors++;
                        $display("FAIL contention_gap got %0d want 3", cyc - last_t);
                    end
                end
                last_t = cyc;
                grants++;
                exp_id = ~exp_id;
                tick();
                req0_a = req0_a + 8'd1;
                req1_b = req1_b + 8'd2;
            end else begin
                tick();
            end
            cyc++;
        end
        checks++;
        if (grants != 4) begin
            errors++;
            $display("FAIL contention_timeout got %0d grants want 4", grants);
        end
        drain();
    endtask

    task automatic test_single_add();
        rsp_ready = 1'b1;
        req0_a = 8'd200; req0_b = 8'd100; req0_op = 1'b0;
        req0_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({s1_req0_ready, s1_req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL add_grant got rdy=%b%b want 10", s1_req0_ready, s1_req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({s1_rsp_valid, s1_busy, s1_calc_num1, s1_calc_num2, s1_calc_sel} !== {1'b0, 1'b1, 8'd200, 8'd100, 1'b0}) begin
            errors++;
            $display("FAIL add_exec got rv=%b busy=%b num1=%0d num2=%0d sel=%b want 0 1 200 100 0",
                     s1_rsp_valid, s1_busy, s1_calc_num1, s1_calc_num2, s1_calc_sel);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({s1_rsp_valid, s1_rsp_id, s1_rsp_data, s1_rsp_flow} !== {1'b1, 1'b0, 8'd44, 1'b1}) begin
            errors++;
            $display("FAIL add_rsp got rv=%b id=%b data=%0d flow=%b want 1 0 44 1", s1_rsp_valid, s1_rsp_id, s1_rsp_data, s1_rsp_flow);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({s1_busy, s1_rsp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL add_idle got busy=%b rv=%b want 0 0", s1_busy, s1_rsp_valid);
        end
        drain();
    endtask

    // Operands on req1 change after the grant; the unit must keep seeing 5-10.
    task automatic test_single_sub();
        rsp_ready = 1'b1;
        req1_a = 8'd5; req1_b = 8'd10; req1_op = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({s1_req0_ready, s1_req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL sub_grant got rdy=%b%b want 01", s1_req0_ready, s1_req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        req1_a = 8'd99; req1_b = 8'd1; req1_op = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({s1_calc_num1, s1_calc_num2, s1_calc_sel} !== {8'd5, 8'd10, 1'b1}) begin
                errors++;
                $display("FAIL sub_hold%0d got num1=%0d num2=%0d sel=%b want 5 10 1", i, s1_calc_num1, s1_calc_num2, s1_calc_sel);
            end
            if (i == 1) begin
                checks++;
                if ({s1_rsp_valid, s1_rsp_id, s1_rsp_data, s1_rsp_flow} !== {1'b1, 1'b1, 8'd251, 1'b1}) begin
                    errors++;
                    $display("FAIL sub_rsp got rv=%b id=%b data=%0d flow=%b want 1 1 251 1", s1_rsp_valid, s1_rsp_id, s1_rsp_data, s1_rsp_flow);
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_backpressure();
        int n = 0;
        rsp_ready = 1'b0;
        req0_a = 8'd77; req0_b = 8'd88; req0_op = 1'b1;
        req0_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({s1_req0_ready, s1_req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL bp_grant got rdy=%b%b want 10", s1_req0_ready, s1_req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        @(negedge clk);
        while (s1_rsp_valid !== 1'b1 && n < 10) begin
            tick();
            @(negedge clk);
            n++;
        end
        checks++;
        if ({s1_rsp_valid, s1_rsp_id, s1_rsp_data, s1_rsp_flow} !== {1'b1, 1'b0, 8'd245, 1'b1}) begin
            errors++;
            $display("FAIL bp_rsp got rv=%b id=%b data=%0d flow=%b want 1 0 245 1", s1_rsp_valid, s1_rsp_id, s1_rsp_data, s1_rsp_flow);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if ({s1_rsp_valid, s1_rsp_id, s1_rsp_data, s1_rsp_flow, s1_req0_ready, s1_req1_ready, s1_busy}
                    !== {1'b1, 1'b0, 8'd245, 1'b1, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL bp_hold%0d got rv=%b id=%b data=%0d flow=%b rdy=%b%b busy=%b want 1 0 245 1 00 1",
                         i, s1_rsp_valid, s1_rsp_id, s1_rsp_data, s1_rsp_flow, s1_req0_ready, s1_req1_ready, s1_busy);
            end
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({s1_rsp_valid, s1_req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL bp_accept_cycle got rv=%b rdy1=%b want 1 0", s1_rsp_valid, s1_req1_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({s1_rsp_valid, s1_req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_next_grant got rv=%b rdy1=%b want 0 1", s1_rsp_valid, s1_req1_ready);
        end
        tick();
        drain();
    endtask

    // Reset lands in the first EXEC cycle; pointer was just moved to req0.
    task automatic test_reset_mid_op();
        rsp_ready = 1'b1;
        req0_a = 8'd33; req0_b = 8'd44; req0_op = 1'b0;
        req0_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (s3_req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_grant got rdy0=%b want 1", s3_req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({s3_calc_num1, s3_calc_num2, s3_calc_sel, s3_rsp_valid, s3_rsp_id, s3_rsp_data,
             s3_rsp_flow, s3_busy, s3_req0_ready, s3_req1_ready} !== 31'd0) begin
            errors++;
            $display("FAIL rstmid_s3_outputs got num1=%0d num2=%0d sel=%b rv=%b id=%b data=%0d flow=%b busy=%b want all 0",
                     s3_calc_num1, s3_calc_num2, s3_calc_sel, s3_rsp_valid, s3_rsp_id, s3_rsp_data, s3_rsp_flow, s3_busy);
        end
        checks++;
        if ({s1_calc_num1, s1_rsp_valid, s1_rsp_data, s1_busy} !== 18'd0) begin
            errors++;
            $display("FAIL rstmid_s1_outputs got num1=%0d rv=%b data=%0d busy=%b want all 0", s1_calc_num1, s1_rsp_valid, s1_rsp_data, s1_busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if ({s1_rsp_valid, s3_rsp_valid} !== 2'b00) begin
                errors++;
                $display("FAIL rstmid_no_rsp%0d got rv=%b%b want 00", i, s1_rsp_valid, s3_rsp_valid);
            end
        end
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({s3_req0_ready, s3_req1_ready, s1_req0_ready, s1_req1_ready} !== 4'b1010) begin
            errors++;
            $display("FAIL rstmid_pointer got s3=%b%b s1=%b%b want 10 10", s3_req0_ready, s3_req1_ready, s1_req0_ready, s1_req1_ready);
        end
        tick();
        drain();
    endtask

    task automatic send0(input logic [7:0] a, input logic [7:0] b, input logic op);
        int n = 0;
        req0_a = a; req0_b = b; req0_op = op;
        req0_valid = 1'b1;
        @(negedge clk);
        while (s1_req0_ready !== 1'b1 && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        checks++;
        if (s1_req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL sweep_accept_timeout a=%0d b=%0d op=%b got rdy0=%b want 1", a, b, op, s1_req0_ready);
        end
        tick();
    endtask

    // Corner operands on both ops, then random ones; results checked by the scoreboards.
    task automatic test_sweep();
        logic [7:0] vals[6];
        vals = '{8'd0, 8'd1, 8'd127, 8'd128, 8'd254, 8'd255};
        rsp_ready = 1'b1;
        for (int op = 0; op < 2; op++)
            for (int i = 0; i < 6; i++)
                for (int j = 0; j < 6; j++)
                    send0(vals[i], vals[j], op[0]);
        for (int k = 0; k < 1200; k++)
            send0(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        drain();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_add();
        test_single_sub();
        test_backpressure();
        test_reset_mid_op();
        test_sweep();
        checks++;
        if (sb1.size() != 0 || sb3.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d/%0d pending want 0/0", sb1.size(), sb3.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
